onp_eval_stack: RTL and testbench
=================================

ONP_EVAL_STACK -- requirements
Module: onp_eval_stack

Interface
REQ-001 Parameter DATA_W, default 32, result/stack word width in bits; legal range 8..64.
REQ-002 Parameter STACK_DEPTH, default 8, operand stack entries; legal range 2..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_data  input  4  RPN token from upstream FIFO: 0-9 digit, A add, B sub, C mul, D equal, E/F brackets (illegal here).
REQ-006 i_data_ready  input  1  upstream FIFO non-empty; i_data valid.
REQ-007 ack_data  output  1  one-cycle pop strobe to upstream FIFO.
REQ-008 o_result  output  DATA_W  signed result of last completed expression.
REQ-009 o_result_ready  output  1  level, o_result valid.
REQ-010 o_error  output  1  level, last expression aborted.
REQ-011 o_err_code  output  2  0 none, 1 underflow, 2 overflow, 3 bad token / bad final depth.
REQ-012 o_sat  output  1  level, saturation occurred in last expression (0 when ONP_SAT_EN undefined).

Function
REQ-013 FSM states: S_IDLE, S_EXEC, S_WAIT, S_ERR.
REQ-014 S_IDLE with i_data_ready=1: latch i_data into token register, register ack_data=1 for exactly next cycle, go S_EXEC; else stay.
REQ-015 S_EXEC executes latched token in one cycle, then S_WAIT (lets FIFO flag update), then S_IDLE; throughput one token per 3 cycles.
REQ-016 Accepting first token of a new expression clears o_result_ready, o_error, o_err_code, o_sat in that same edge.
REQ-017 Digit: zero-extend to DATA_W and push; stack full -> error code 2.
REQ-018 A/B/C: pop b (top), pop a, push a+b / a-b / a*b; count<2 -> error code 1.
REQ-019 Arithmetic two's-complement signed; without ONP_SAT_EN result is low DATA_W bits (wrap); multiply uses 2*DATA_W product internally.
REQ-020 D with count==1: o_result<=top, o_result_ready<=1, stack cleared, back to S_WAIT/S_IDLE.
REQ-021 D with count!=1 -> error code 3; E or F token -> error code 3.
REQ-022 On error: o_error<=1, o_err_code set (first error only), stack cleared, enter S_ERR.
REQ-023 S_ERR: keep accepting and acking tokens with same 3-cycle cadence, discard them, return to S_IDLE after the D token is consumed; o_error remains held.
REQ-024 o_result holds value until next successful D; not cleared by errors.
REQ-025 ack_data never asserted when i_data_ready=0 at acceptance; never two pulses on consecutive cycles.

Reset
REQ-026 rst=1 at any clock edge, including mid-expression: state S_IDLE, stack count 0, ack_data=0, o_result=0, o_result_ready=0, o_error=0, o_err_code=0, o_sat=0.
REQ-027 Stack RAM contents need no reset; only count/pointer is reset.

Configuration
REQ-028 Macro ONP_SAT_EN defined: A/B/C results clamp to signed max/min of DATA_W and set o_sat sticky for the expression.
REQ-029 ONP_SAT_EN undefined: wrapping arithmetic, o_sat tied 0, no clamp logic synthesised.

Structure
REQ-030 Package onp_pkg holds token constants (TOK_ADD=4'hA, TOK_SUB=4'hB, TOK_MUL=4'hC, TOK_EQ=4'hD, TOK_LB=4'hE, TOK_RB=4'hF), error-code constants, FSM state enum.
REQ-031 Sub-module onp_stack: parametrised LIFO (DATA_W, STACK_DEPTH) with push, pop2-push1, clear, top/next-top read, count, full/empty; sync active-high reset on count.

Verification
REQ-032 Tokens 7,1,B,5,A,D -> o_result=11, o_result_ready=1, o_error=0; ack_data pulses exactly 6 times.
REQ-033 Tokens 1,9,B,D -> o_result=-8 (32'hFFFFFFF8).
REQ-034 DATA_W=8: tokens 9,9,C,9,C,D -> without ONP_SAT_EN o_result=-39 (8'hD9), o_sat=0; with ONP_SAT_EN o_result=127, o_sat=1.
REQ-035 Tokens 3,A,4,D -> o_error=1, o_err_code=1, all 4 tokens acked, o_result unchanged; next expression 2,D -> o_result=2, o_error=0.
REQ-036 STACK_DEPTH=4: tokens 1,2,3,4,5,D -> o_err_code=2; token E,D -> o_err_code=3.
REQ-037 rst pulsed after tokens 7,1 accepted, then 4,D -> o_result=4, no error.

Source files
------------

// File: rtl/onp_pkg.sv
// Shared token encodings, error codes and FSM state type for the RPN evaluator.
package onp_pkg;

  localparam logic [3:0] TOK_MAX_DIGIT = 4'h9;
  localparam logic [3:0] TOK_ADD       = 4'hA;
  localparam logic [3:0] TOK_SUB       = 4'hB;
  localparam logic [3:0] TOK_MUL       = 4'hC;
  localparam logic [3:0] TOK_EQ        = 4'hD;
  localparam logic [3:0] TOK_LB        = 4'hE;
  localparam logic [3:0] TOK_RB        = 4'hF;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_BAD       = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT,
    S_ERR
  } state_t;

  function automatic logic is_digit(input logic [3:0] t);
    return t <= TOK_MAX_DIGIT;
  endfunction

  function automatic logic is_arith(input logic [3:0] t);
    return (t == TOK_ADD) || (t == TOK_SUB) || (t == TOK_MUL);
  endfunction

endpackage

// File: rtl/onp_stack.sv
// Parametrised operand LIFO: push, pop-two-push-one, clear; count is the only reset state.
module onp_stack
  import onp_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop2_push1,
  input  logic                               clear,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  top,
  output logic [DATA_W-1:0]                  next_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   count,
  output logic                               full,
  output logic                               empty
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [DATA_W-1:0] mem [STACK_DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  wr_ptr, top_ptr, nxt_ptr;
  logic              do_push, do_pop2;

  assign wr_ptr  = PTR_W'(cnt);
  assign top_ptr = PTR_W'(cnt - CNT_W'(1));
  assign nxt_ptr = PTR_W'(cnt - CNT_W'(2));

  assign full  = (cnt == CNT_W'(STACK_DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  assign top      = mem[top_ptr];
  assign next_top = mem[nxt_ptr];

  assign do_push = push && !full && !clear;
  assign do_pop2 = pop2_push1 && (cnt >= CNT_W'(2)) && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + CNT_W'(1);
    end else if (do_pop2) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // The combined result overwrites the slot that held the second operand.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end else if (do_pop2) begin
      mem[nxt_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/onp_eval_stack.sv
// RPN expression evaluator fed one token per 3 cycles from an upstream FIFO.
// Optional clamp-to-range arithmetic is enabled by defining ONP_SAT_EN.
module onp_eval_stack
  import onp_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        i_data,
  input  logic              i_data_ready,
  output logic              ack_data,
  output logic [DATA_W-1:0] o_result,
  output logic              o_result_ready,
  output logic              o_error,
  output logic [1:0]        o_err_code,
  output logic              o_sat
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  state_t            state, next_state;
  logic [3:0]        tok;
  logic              err_mode, expr_start;
  logic              accept, new_expr, in_exec, err_drain_end;
  logic              do_push, do_op, do_eq, raise_err, stk_clear;
  logic [1:0]        err_code_c;
  logic [DATA_W-1:0] op_res, stk_wdata, stk_top, stk_next;
  logic [CNT_W-1:0]  stk_cnt;
  logic              stk_full, stk_empty;

  onp_stack #(
    .DATA_W      (DATA_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk        (clk),
    .rst        (rst),
    .push       (do_push),
    .pop2_push1 (do_op),
    .clear      (stk_clear),
    .wr_data    (stk_wdata),
    .top        (stk_top),
    .next_top   (stk_next),
    .count      (stk_cnt),
    .full       (stk_full),
    .empty      (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      S_IDLE, S_ERR: begin
        if (i_data_ready) begin
          accept     = 1'b1;
          next_state = S_EXEC;
        end
      end
      S_EXEC:  next_state = S_WAIT;
      S_WAIT:  next_state = err_mode ? S_ERR : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign new_expr      = accept && (state == S_IDLE) && expr_start;
  assign in_exec       = (state == S_EXEC) && !err_mode;
  assign err_drain_end = (state == S_EXEC) && err_mode && (tok == TOK_EQ);

  always_comb begin
    err_code_c = ERR_NONE;
    if (is_digit(tok)) begin
      if (stk_full) err_code_c = ERR_OVERFLOW;
    end else if (is_arith(tok)) begin
      if (stk_empty || (stk_cnt == CNT_W'(1))) err_code_c = ERR_UNDERFLOW;
    end else if (tok == TOK_EQ) begin
      if (stk_cnt != CNT_W'(1)) err_code_c = ERR_BAD;
    end else begin
      err_code_c = ERR_BAD;
    end
  end

  assign do_push   = in_exec && is_digit(tok) && (err_code_c == ERR_NONE);
  assign do_op     = in_exec && is_arith(tok) && (err_code_c == ERR_NONE);
  assign do_eq     = in_exec && (tok == TOK_EQ) && (err_code_c == ERR_NONE);
  assign raise_err = in_exec && (err_code_c != ERR_NONE);
  assign stk_clear = do_eq || raise_err;
  assign stk_wdata = do_op ? op_res : {{(DATA_W-4){1'b0}}, tok};

`ifdef ONP_SAT_EN
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0]     sum_w, diff_w, prod_hi;
  logic [2*DATA_W-1:0] prod_w;
  logic                op_sat, op_neg, sat_r;

  always_comb begin
    sum_w   = {stk_next[DATA_W-1], stk_next} + {stk_top[DATA_W-1], stk_top};
    diff_w  = {stk_next[DATA_W-1], stk_next} - {stk_top[DATA_W-1], stk_top};
    prod_w  = $signed({{DATA_W{stk_next[DATA_W-1]}}, stk_next}) *
              $signed({{DATA_W{stk_top[DATA_W-1]}}, stk_top});
    prod_hi = prod_w[2*DATA_W-1:DATA_W-1];
    op_res  = sum_w[DATA_W-1:0];
    op_sat  = 1'b0;
    op_neg  = 1'b0;
    unique case (tok)
      TOK_SUB: begin
        op_res = diff_w[DATA_W-1:0];
        op_sat = diff_w[DATA_W] != diff_w[DATA_W-1];
        op_neg = diff_w[DATA_W];
      end
      TOK_MUL: begin
        op_res = prod_w[DATA_W-1:0];
        op_sat = !((&prod_hi) || !(|prod_hi));
        op_neg = prod_w[2*DATA_W-1];
      end
      default: begin
        op_res = sum_w[DATA_W-1:0];
        op_sat = sum_w[DATA_W] != sum_w[DATA_W-1];
        op_neg = sum_w[DATA_W];
      end
    endcase
    if (op_sat) op_res = op_neg ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_r <= 1'b0;
    end else if (new_expr) begin
      sat_r <= 1'b0;
    end else if (do_op && op_sat) begin
      sat_r <= 1'b1;
    end
  end

  assign o_sat = sat_r;
`else
  always_comb begin
    unique case (tok)
      TOK_SUB: op_res = stk_next - stk_top;
      TOK_MUL: op_res = stk_next * stk_top;
      default: op_res = stk_next + stk_top;
    endcase
  end

  assign o_sat = 1'b0;
`endif

  // A bad-depth '=' has itself closed the expression, so it skips the error drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      tok            <= '0;
      ack_data       <= 1'b0;
      err_mode       <= 1'b0;
      expr_start     <= 1'b1;
      o_result       <= '0;
      o_result_ready <= 1'b0;
      o_error        <= 1'b0;
      o_err_code     <= ERR_NONE;
    end else begin
      ack_data <= accept;
      if (accept) tok <= i_data;
      if (new_expr) begin
        expr_start     <= 1'b0;
        o_result_ready <= 1'b0;
        o_error        <= 1'b0;
        o_err_code     <= ERR_NONE;
      end
      if (do_eq) begin
        o_result       <= stk_top;
        o_result_ready <= 1'b1;
        expr_start     <= 1'b1;
      end
      if (raise_err) begin
        o_error    <= 1'b1;
        o_err_code <= err_code_c;
        if (tok == TOK_EQ) begin
          expr_start <= 1'b1;
        end else begin
          err_mode <= 1'b1;
        end
      end
      if (err_drain_end) begin
        err_mode   <= 1'b0;
        expr_start <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_onp_eval_stack.sv
// Scoreboard bench: two evaluator instances (32-bit/depth 4 and 8-bit/depth 8) fed from modelled FIFOs.
module tb_onp_eval_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a_data, b_data;
  logic        a_rdy, b_rdy, a_ack, b_ack;
  logic [31:0] a_res;
  logic [7:0]  b_res;
  logic        a_rr, b_rr, a_err, b_err, a_sat, b_sat;
  logic [1:0]  a_code, b_code;

  int total = 0;
  int bad   = 0;
  int a_acks = 0;
  int b_acks = 0;

  typedef struct {
    bit          is_err;
    logic [63:0] val;
    logic [1:0]  code;
    bit          sat;
  } exp_t;

  logic [3:0] a_q[$];
  logic [3:0] b_q[$];
  exp_t       a_sb[$];
  exp_t       b_sb[$];

  always #5 clk = ~clk;

  onp_eval_stack #(
    .DATA_W      (32),
    .STACK_DEPTH (4)
  ) dut_a (
    .clk            (clk),
    .rst            (rst),
    .i_data         (a_data),
    .i_data_ready   (a_rdy),
    .ack_data       (a_ack),
    .o_result       (a_res),
    .o_result_ready (a_rr),
    .o_error        (a_err),
    .o_err_code     (a_code),
    .o_sat          (a_sat)
  );

  onp_eval_stack #(
    .DATA_W (8)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .i_data         (b_data),
    .i_data_ready   (b_rdy),
    .ack_data       (b_ack),
    .o_result       (b_res),
    .o_result_ready (b_rr),
    .o_error        (b_err),
    .o_err_code     (b_code),
    .o_sat          (b_sat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_entry(input string name, input exp_t e, input bit is_err,
                             input logic [63:0] res, input logic [1:0] code,
                             input logic sat, input logic err);
    chk({name, "_kind"}, 64'(is_err), 64'(e.is_err));
    chk({name, "_result"}, res, e.val);
    if (e.is_err) begin
      chk({name, "_code"}, 64'(code), 64'(e.code));
    end else begin
      chk({name, "_sat"}, 64'(sat), 64'(e.sat));
      chk({name, "_err_low"}, 64'(err), 64'd0);
    end
  endtask

  // FIFO model + monitor for instance A
  initial begin : mon_a
    logic ack_q, rr_q, err_q;
    exp_t e;
    ack_q = 1'b0; rr_q = 1'b0; err_q = 1'b0;
    a_rdy = 1'b0; a_data = 4'h0;
    forever begin
      @(negedge clk);
      if (a_ack) begin
        a_acks++;
        total++;
        if (a_q.size() == 0 || ack_q) begin
          bad++;
          $display("FAIL a_ack_proto: ack with queued=%0d prev_ack=%0b, expected pending token and no back-to-back",
                   a_q.size(), ack_q);
        end else begin
          void'(a_q.pop_front());
        end
      end
      ack_q = a_ack;
      if (a_rr && !rr_q) begin
        if (a_sb.size() == 0) begin
          chk("a_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = a_sb.pop_front();
          check_entry("a_res", e, 1'b0, 64'(a_res), a_code, a_sat, a_err);
        end
      end
      if (a_err && !err_q) begin
        if (a_sb.size() == 0) begin
          chk("a_unexpected_error", 64'd1, 64'd0);
        end else begin
          e = a_sb.pop_front();
          check_entry("a_err", e, 1'b1, 64'(a_res), a_code, a_sat, a_err);
        end
      end
      rr_q  = a_rr;
      err_q = a_err;
      a_rdy  = (a_q.size() != 0);
      a_data = a_rdy ? a_q[0] : 4'h0;
    end
  end

  // FIFO model + monitor for instance B
  initial begin : mon_b
    logic ack_q, rr_q, err_q;
    exp_t e;
    ack_q = 1'b0; rr_q = 1'b0; err_q = 1'b0;
    b_rdy = 1'b0; b_data = 4'h0;
    forever begin
      @(negedge clk);
      if (b_ack) begin
        b_acks++;
        total++;
        if (b_q.size() == 0 || ack_q) begin
          bad++;
          $display("FAIL b_ack_proto: ack with queued=%0d prev_ack=%0b, expected pending token and no back-to-back",
                   b_q.size(), ack_q);
        end else begin
          void'(b_q.pop_front());
        end
      end
      ack_q = b_ack;
      if (b_rr && !rr_q) begin
        if (b_sb.size() == 0) begin
          chk("b_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = b_sb.pop_front();
          check_entry("b_res", e, 1'b0, 64'(b_res), b_code, b_sat, b_err);
        end
      end
      if (b_err && !err_q) begin
        if (b_sb.size() == 0) begin
          chk("b_unexpected_error", 64'd1, 64'd0);
        end else begin
          e = b_sb.pop_front();
          check_entry("b_err", e, 1'b1, 64'(b_res), b_code, b_sat, b_err);
        end
      end
      rr_q  = b_rr;
      err_q = b_err;
      b_rdy  = (b_q.size() != 0);
      b_data = b_rdy ? b_q[0] : 4'h0;
    end
  end

  task automatic expect_res(input bit which, input logic [63:0] v, input bit s);
    exp_t e;
    e.is_err = 1'b0; e.val = v; e.code = 2'd0; e.sat = s;
    if (which) b_sb.push_back(e); else a_sb.push_back(e);
  endtask

  task automatic expect_err(input bit which, input logic [1:0] c, input logic [63:0] held);
    exp_t e;
    e.is_err = 1'b1; e.val = held; e.code = c; e.sat = 1'b0;
    if (which) b_sb.push_back(e); else a_sb.push_back(e);
  endtask

  // Tokens packed first-token-in-most-significant-nibble.
  task automatic run(input bit which, input string name, input logic [63:0] toks, input int n);
    int a0;
    int w;
    logic [3:0] t;
    a0 = which ? b_acks : a_acks;
    for (int i = 0; i < n; i++) begin
      t = toks[(n-1-i)*4 +: 4];
      if (which) b_q.push_back(t); else a_q.push_back(t);
    end
    w = 0;
    while (((which ? b_q.size() : a_q.size()) != 0 ||
            (which ? b_sb.size() : a_sb.size()) != 0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (w >= 400) begin
      bad++;
      $display("FAIL %s_timeout: waited %0d cycles, expected drain within 400", name, w);
    end
    repeat (4) @(negedge clk);
    chk({name, "_acks"}, 64'((which ? b_acks : a_acks) - a0), 64'(n));
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_a_result"}, 64'(a_res), 64'd0);
    chk({name, "_a_rr"},     64'(a_rr),  64'd0);
    chk({name, "_a_err"},    64'(a_err), 64'd0);
    chk({name, "_a_code"},   64'(a_code), 64'd0);
    chk({name, "_a_sat"},    64'(a_sat), 64'd0);
    chk({name, "_a_ack"},    64'(a_ack), 64'd0);
    chk({name, "_b_result"}, 64'(b_res), 64'd0);
    chk({name, "_b_rr"},     64'(b_rr),  64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_checks("reset");

    expect_res(1'b0, 64'd11, 1'b0);
    run(1'b0, "add_sub", 64'h71B5AD, 6);

    expect_res(1'b0, 64'hFFFF_FFF8, 1'b0);
    run(1'b0, "neg_sub", 64'h19BD, 4);

    expect_err(1'b0, 2'd1, 64'hFFFF_FFF8);
    run(1'b0, "underflow", 64'h3A4D, 4);
    chk("underflow_err_held", 64'(a_err), 64'd1);
    chk("underflow_code_held", 64'(a_code), 64'd1);
    chk("underflow_result_held", 64'(a_res), 64'hFFFF_FFF8);

    expect_res(1'b0, 64'd2, 1'b0);
    run(1'b0, "recover", 64'h2D, 2);
    chk("recover_err_clr", 64'(a_err), 64'd0);

    expect_err(1'b0, 2'd2, 64'd2);
    run(1'b0, "overflow", 64'h12345D, 6);

    expect_err(1'b0, 2'd3, 64'd2);
    run(1'b0, "bad_token", 64'hED, 2);

    expect_err(1'b0, 2'd3, 64'd2);
    run(1'b0, "bad_depth", 64'hD, 1);

    expect_res(1'b0, 64'd8, 1'b0);
    run(1'b0, "after_bad_depth", 64'h8D, 2);

`ifdef ONP_SAT_EN
    expect_res(1'b1, 64'h7F, 1'b1);
`else
    expect_res(1'b1, 64'hD9, 1'b0);
`endif
    run(1'b1, "mul_ovf", 64'h99C9CD, 6);

    expect_res(1'b1, 64'hB8, 1'b0);
    run(1'b1, "neg_mul", 64'h19B9CD, 6);

`ifdef ONP_SAT_EN
    expect_res(1'b1, 64'h80, 1'b1);
`else
    expect_res(1'b1, 64'h27, 1'b0);
`endif
    run(1'b1, "neg_mul_ovf", 64'h09B9C9CD, 8);

    run(1'b0, "partial", 64'h71, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_checks("mid_reset");

    expect_res(1'b0, 64'd4, 1'b0);
    run(1'b0, "post_reset", 64'h4D, 2);
    chk("post_reset_err", 64'(a_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
